dir_input_queue: RTL and testbench
==================================

Name: dir_input_queue

Overview:
Sits between button_sync and game_path. It converts the synchronized, active-high LEFT/UP/DOWN/RIGHT levels into single press events and queues legal direction changes in a small FIFO. game_path pops one queued direction per move tick, so fast key sequences (e.g. UP then LEFT inside one tick) are not lost. Reversals and repeats are rejected at enqueue time.

Parameters:
DEPTH, 2, queue entries; legal range 1..4.
INIT_DIR, DIR_RIGHT, value of cur_dir after reset or clear.

Ports:
CLOCK_50  in  1  system clock.
rst_n  in  1  reset.
in_up  in  1  synchronized key level, active-high.
in_right  in  1  synchronized key level, active-high.
in_down  in  1  synchronized key level, active-high.
in_left  in  1  synchronized key level, active-high.
clear  in  1  synchronous flush: empty the queue and set cur_dir to INIT_DIR (new game).
take  in  1  one-cycle pulse from game_path at each move tick.
cur_dir  out  2  direction the snake is moving (dir_t).
next_dir  out  2  head of queue if count>0, else cur_dir (combinational).
q_count  out  3  entries held, 0..DEPTH.
press_any  out  1  registered 1-cycle pulse on any new key press (game start trigger).
drop  out  1  registered 1-cycle pulse when a press is rejected.

Behaviour:
- Reset is rst_n, synchronous, active-low, on clock CLOCK_50. Reset values: cur_dir=INIT_DIR, q_count=0, press_any=0, drop=0, queue pointers=0, prev_keys=4'b1111.
- prev_keys resets to all ones so a key held through reset produces no press.
- Edge detect: press = keys & ~prev_keys. prev_keys <= keys every cycle, including during clear.
- Several new presses in one cycle: priority UP>RIGHT>DOWN>LEFT. Only the winner is a candidate. The losers are ignored and do not assert drop.
- Reference direction: tail = last queued entry if count>0, else cur_dir. Both are taken before this cycle's pop.
- Reject the candidate if it equals tail or equals tail^2'b10 (reversal). Reject it if count==DEPTH and take=0. On reject, drop=1 on the next cycle.
- Accept otherwise and write at wr_ptr. q_count is visible +1 on the next cycle, so press-to-q_count latency is 1 cycle.
- take with count>0: cur_dir <= head, rd_ptr advances.
- take with count==0: cur_dir is unchanged.
- take with count==0 and an accepted candidate in the same cycle: bypass, cur_dir <= candidate and the queue stays empty.
- take with count==DEPTH and an accepted candidate: pop and push in the same cycle, count unchanged.
- Pointers wrap modulo DEPTH; no power-of-2 requirement (explicit compare-and-zero).
- press_any <= |press. It asserts regardless of clear and regardless of acceptance.
- clear beats take and push. Pointers go to 0, count to 0, cur_dir to INIT_DIR; any press in that cycle is discarded and drop is not asserted.
- Reset mid-operation aborts everything; no queued direction survives.
- No combinational path from inputs to outputs except next_dir, which depends only on state.

Decomposition:
- Package snake_pkg holds:
  - typedef enum logic [1:0] dir_t {DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3};
  - function opposite(dir_t) returning d^2'b10;
  - constant GRID_W=16 and GRID_H=16, shared with game_path and game_plot.
- Sub-module dir_fifo (DEPTH entries of dir_t; push/pop/flush; head, tail, count) holds the storage.
- The top level holds edge detect, priority, legality check and bypass.

Test Plan:
- Reset with in_up held high, then release and re-press: no press_any during hold. Re-press gives press_any=1 one cycle after the edge, q_count=1, next_dir=DIR_UP.
- cur_dir=RIGHT, press LEFT -> drop=1, q_count stays 0. Press RIGHT -> drop=1.
- cur_dir=RIGHT, press UP then LEFT 3 cycles apart, no take -> q_count=2. Two take pulses give cur_dir=UP, then cur_dir=LEFT, q_count=0.
- DEPTH=2, queue [UP,LEFT], press DOWN with take=0 -> drop=1. Repeat with take=1 in the same cycle -> cur_dir=UP, queue [LEFT,DOWN], q_count=2.
- Empty queue, cur_dir=RIGHT, press DOWN in the same cycle as take -> next cycle cur_dir=DOWN, q_count=0.
- Queue [UP], assert clear with a simultaneous in_left edge -> cur_dir=RIGHT, q_count=0, drop=0, press_any=1.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: direction type, grid size and helpers shared by the snake game blocks.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   localparam int GRID_W = 16;
   localparam int GRID_H = 16;

   // Encoding puts each direction two steps from its reverse, so flipping bit 1 reverses.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// dir_fifo: small circular queue of directions with flush, exposing head, tail and count.
module dir_fifo
   import snake_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  dir_t       push_dir,
   output dir_t       head,
   output dir_t       tail,
   output logic [2:0] count
);

   dir_t       r_mem [4];
   logic [1:0] r_rd, r_wr;
   logic [2:0] r_cnt;
   logic [1:0] w_rd_nxt, w_wr_nxt, w_wr_prev;

   // Explicit wrap so any depth from 1 to 4 works without power-of-2 pointers.
   assign w_rd_nxt  = (r_rd == 2'(DEPTH - 1)) ? 2'd0 : r_rd + 2'd1;
   assign w_wr_nxt  = (r_wr == 2'(DEPTH - 1)) ? 2'd0 : r_wr + 2'd1;
   assign w_wr_prev = (r_wr == 2'd0) ? 2'(DEPTH - 1) : r_wr - 2'd1;

   assign head  = r_mem[r_rd];
   assign tail  = r_mem[w_wr_prev];
   assign count = r_cnt;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         r_rd  <= 2'd0;
         r_wr  <= 2'd0;
         r_cnt <= 3'd0;
      end else if (flush) begin
         r_rd  <= 2'd0;
         r_wr  <= 2'd0;
         r_cnt <= 3'd0;
      end else begin
         r_rd  <= pop ? w_rd_nxt : r_rd;
         r_wr  <= push ? w_wr_nxt : r_wr;
         r_cnt <= r_cnt + {2'b00, push} - {2'b00, pop};
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst_n && !flush && push)
         r_mem[r_wr] <= push_dir;
   end

endmodule

// File: rtl/dir_input_queue.sv
// dir_input_queue: turns key levels into press events and queues legal direction changes.
module dir_input_queue
   import snake_pkg::*;
#(
   parameter int   DEPTH    = 2,
   parameter dir_t INIT_DIR = DIR_RIGHT
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       in_up,
   input  logic       in_right,
   input  logic       in_down,
   input  logic       in_left,
   input  logic       clear,
   input  logic       take,
   output dir_t       cur_dir,
   output dir_t       next_dir,
   output logic [2:0] q_count,
   output logic       press_any,
   output logic       drop
);

   logic [3:0] r_prev, w_keys, w_press;
   dir_t       r_cur, w_cand, w_head, w_tail, w_ref;
   logic [2:0] w_count;
   logic       r_press_any, r_drop;
   logic       w_valid, w_reject, w_accept, w_empty, w_full, w_bypass, w_push, w_pop;

   // Bit index equals the dir_t value, so the lowest set bit is the priority winner.
   assign w_keys  = {in_left, in_down, in_right, in_up};
   assign w_press = w_keys & ~r_prev;
   assign w_valid = |w_press;

   always_comb begin
      w_cand = w_press[0] ? DIR_UP :
               w_press[1] ? DIR_RIGHT :
               w_press[2] ? DIR_DOWN : DIR_LEFT;
   end

   assign w_empty  = (w_count == 3'd0);
   assign w_full   = (w_count == 3'(DEPTH));
   assign w_ref    = w_empty ? r_cur : w_tail;
   assign w_reject = w_valid & ((w_cand == w_ref) | (w_cand == opposite(w_ref)) | (w_full & ~take));
   assign w_accept = w_valid & ~w_reject & ~clear;
   assign w_bypass = w_accept & take & w_empty;
   assign w_push   = w_accept & ~w_bypass;
   assign w_pop    = take & ~w_empty & ~clear;

   dir_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .flush    (clear),
      .push     (w_push),
      .pop      (w_pop),
      .push_dir (w_cand),
      .head     (w_head),
      .tail     (w_tail),
      .count    (w_count)
   );

   // Key history resets high so a key held through reset is not seen as a press.
   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         r_prev      <= 4'hF;
         r_cur       <= INIT_DIR;
         r_press_any <= 1'b0;
         r_drop      <= 1'b0;
      end else begin
         r_prev      <= w_keys;
         r_press_any <= w_valid;
         r_drop      <= w_reject & ~clear;
         r_cur       <= clear ? INIT_DIR : w_bypass ? w_cand : w_pop ? w_head : r_cur;
      end
   end

   assign cur_dir   = r_cur;
   assign next_dir  = w_empty ? r_cur : w_head;
   assign q_count   = w_count;
   assign press_any = r_press_any;
   assign drop      = r_drop;

endmodule

// File: tb/tb_dir_input_queue.sv
// tb_dir_input_queue: directed plan scenarios plus random key traffic against a queue-based model.
module tb_dir_input_queue;
   import snake_pkg::*;

   localparam int DEPTH = 2;

   logic       CLOCK_50 = 1'b0;
   logic       rst_n    = 1'b0;
   logic       in_up = 1'b0, in_right = 1'b0, in_down = 1'b0, in_left = 1'b0;
   logic       clear = 1'b0, take = 1'b0;
   dir_t       cur_dir, next_dir;
   logic [2:0] q_count;
   logic       press_any, drop;

   always #5 CLOCK_50 = ~CLOCK_50;

   dir_input_queue #(.DEPTH(DEPTH), .INIT_DIR(DIR_RIGHT)) dut (
      .CLOCK_50  (CLOCK_50),
      .rst_n     (rst_n),
      .in_up     (in_up),
      .in_right  (in_right),
      .in_down   (in_down),
      .in_left   (in_left),
      .clear     (clear),
      .take      (take),
      .cur_dir   (cur_dir),
      .next_dir  (next_dir),
      .q_count   (q_count),
      .press_any (press_any),
      .drop      (drop)
   );

   int         n_vec = 0;
   int         n_err = 0;
   dir_t       m_q[$];
   dir_t       m_cur = DIR_RIGHT;
   logic [3:0] m_prev = 4'hF;
   logic       m_pa = 1'b0, m_drop = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // keys: bit0 up, bit1 right, bit2 down, bit3 left
   task automatic model(input logic r, input logic [3:0] k, input logic t, input logic c);
      logic [3:0] press;
      dir_t       w, tl;
      logic       ok;
      if (!r) begin
         m_q.delete();
         m_cur  = DIR_RIGHT;
         m_prev = 4'hF;
         m_pa   = 1'b0;
         m_drop = 1'b0;
         return;
      end
      press  = k & ~m_prev;
      m_prev = k;
      m_pa   = |press;
      if (c) begin
         m_q.delete();
         m_cur  = DIR_RIGHT;
         m_drop = 1'b0;
         return;
      end
      w = DIR_LEFT;
      for (int i = 3; i >= 0; i--)
         if (press[i]) w = dir_t'(i[1:0]);
      tl     = (m_q.size() > 0) ? m_q[$] : m_cur;
      ok     = m_pa && (w != tl) && (w != opposite(tl)) && !(m_q.size() == DEPTH && !t);
      m_drop = m_pa && !ok;
      if (t && m_q.size() > 0) m_cur = m_q.pop_front();
      else if (t && ok) begin
         m_cur = w;
         ok    = 1'b0;
      end
      if (ok) m_q.push_back(w);
   endtask

   task automatic step(input logic r, input logic [3:0] k, input logic t, input logic c);
      @(negedge CLOCK_50);
      rst_n = r;
      {in_left, in_down, in_right, in_up} = k;
      take  = t;
      clear = c;
      model(r, k, t, c);
      @(posedge CLOCK_50);
      #1;
      chk("cur_dir", cur_dir, m_cur);
      chk("q_count", q_count, m_q.size());
      chk("next_dir", next_dir, (m_q.size() > 0) ? m_q[0] : m_cur);
      chk("press_any", press_any, m_pa);
      chk("drop", drop, m_drop);
   endtask

   initial begin
      logic [3:0] k;
      // key held through reset, then released and re-pressed
      step(0, 4'b0001, 0, 0);
      step(0, 4'b0001, 0, 0);
      chk("rst_cur_dir", cur_dir, DIR_RIGHT);
      chk("rst_q_count", q_count, 0);
      step(1, 4'b0001, 0, 0);
      chk("held_no_press", press_any, 0);
      step(1, 4'b0000, 0, 0);
      step(1, 4'b0001, 0, 0);
      chk("repress_pa", press_any, 1);
      chk("repress_cnt", q_count, 1);
      chk("repress_next", next_dir, DIR_UP);
      step(1, 4'b0000, 0, 1);
      // reversal and repeat rejected
      step(1, 4'b1000, 0, 0);
      chk("reverse_drop", drop, 1);
      chk("reverse_cnt", q_count, 0);
      step(1, 4'b0000, 0, 0);
      step(1, 4'b0010, 0, 0);
      chk("repeat_drop", drop, 1);
      step(1, 4'b0000, 0, 0);
      // UP then LEFT, two takes
      step(1, 4'b0001, 0, 0);
      step(1, 4'b0000, 0, 0);
      step(1, 4'b0000, 0, 0);
      step(1, 4'b1000, 0, 0);
      chk("two_cnt", q_count, 2);
      step(1, 4'b0000, 1, 0);
      chk("take1_cur", cur_dir, DIR_UP);
      step(1, 4'b0000, 1, 0);
      chk("take2_cur", cur_dir, DIR_LEFT);
      chk("take2_cnt", q_count, 0);
      // full queue: drop without take, pop+push with take
      step(1, 4'b0000, 0, 1);
      step(1, 4'b0001, 0, 0);
      step(1, 4'b0000, 0, 0);
      step(1, 4'b1000, 0, 0);
      step(1, 4'b0000, 0, 0);
      step(1, 4'b0100, 0, 0);
      chk("full_drop", drop, 1);
      step(1, 4'b0000, 0, 0);
      step(1, 4'b0100, 1, 0);
      chk("full_take_cur", cur_dir, DIR_UP);
      chk("full_take_cnt", q_count, 2);
      chk("full_take_head", next_dir, DIR_LEFT);
      // bypass on empty queue
      step(1, 4'b0000, 0, 1);
      step(1, 4'b0100, 1, 0);
      chk("bypass_cur", cur_dir, DIR_DOWN);
      chk("bypass_cnt", q_count, 0);
      // clear beats a simultaneous press
      step(1, 4'b0000, 0, 1);
      step(1, 4'b0001, 0, 0);
      step(1, 4'b1001, 0, 1);
      chk("clear_cur", cur_dir, DIR_RIGHT);
      chk("clear_cnt", q_count, 0);
      chk("clear_drop", drop, 0);
      chk("clear_pa", press_any, 1);
      // random traffic
      k = 4'b0000;
      for (int n = 0; n < 4000; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 3) == 0) k[b] = ~k[b];
         step($urandom_range(0, 199) != 0, k, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
